draw_scheduler: RTL
===================

// Module: draw_scheduler
// PURPOSE
//  Sequencer in front of drawImage. Game/menu logic pushes draw commands into a FIFO.
//  The scheduler pops them one at a time and holds the image-select fields stable.
//  It issues the go pulse, waits for done, then forms absolute VGA pixel coordinates
//  (base + dx/dy) gated to the 320x240 screen.
// PARAMETERS
//  DEPTH   8    command FIFO entries (power of 2, >=2)
//  AW      3    log2(DEPTH); count port is AW+1 bits
//  X_MAX   320  screen width; pixels with x>=X_MAX are suppressed
//  Y_MAX   240  screen height; pixels with y>=Y_MAX are suppressed
// PORTS
//  clock       in   1   system clock, all logic posedge
//  resetn      in   1   synchronous, active-low reset
//  cmd_valid   in   1   push request
//  cmd_data    in   38  {x[37:29],y[28:20],drawID[19:16],card[15:10],menuOFF[9:6],
//                       menuID[5:4],menuDepth[3:2],winID[1:0]}
//  cmd_ready   out  1   =!full (combinational)
//  di_go       out  1   go pulse to drawImage
//  di_done     in   1   done pulse from drawImage
//  di_drawID/card/menuOFF/menuID/menuDepth/winID  out 4/6/4/2/2/2  held fields of the active cmd
//  di_ld_pos   in   1   drawImage ld_pos
//  di_draw     in   1   drawImage draw_pixel
//  di_dx,di_dy in   9   drawImage offsets
//  vga_x,vga_y out  9   absolute pixel position
//  vga_plot    out  1   write strobe to VGA adapter
//  busy        out  1   draw in progress (state != IDLE)
//  count       out  AW+1  FIFO occupancy
//  overflow    out  1   sticky: push attempted while full
// BEHAVIOUR
//  Reset (resetn=0 at a clock edge): FSM->IDLE; FIFO pointers and count=0; overflow=0;
//   all di_* field regs, vga_x, vga_y = 0; di_go=0; vga_plot=0.
//   A reset mid-draw abandons the cmd; drawImage shares resetn and resets too.
//  FIFO: push when cmd_valid&&!full; pop only in state POP.
//   Push and pop in the same cycle while full: pop frees the slot and push is accepted.
//   Count is unchanged in that case.
//   Push while full with no pop: data dropped, overflow<=1 (cleared only by reset).
//   Pointers wrap mod DEPTH.
//  FSM (one state per cycle unless noted):
//   IDLE: if count!=0 -> POP, else stay.
//   POP : head entry loaded into field regs and base_x/base_y regs; rd_ptr++ -> GO.
//   GO  : di_go=1 for exactly this cycle -> WAIT.
//   WAIT: hold fields; on di_done -> IDLE; otherwise stay.
//         di_done outside WAIT is ignored.
//  Min per-cmd overhead: 3 cycles plus drawImage time; back-to-back cmds leave >=1 idle cycle
//   between done and the next go, matching drawImage's return to its load state.
//  Fields and base regs change only in POP, so they are stable for the whole draw.
//  Coordinates: on di_ld_pos, vga_x<=base_x+di_dx and vga_y<=base_y+di_dy.
//   These are 9-bit sums; carry is discarded (wraps mod 512).
//  vga_plot = di_draw && (vga_x<X_MAX) && (vga_y<Y_MAX) && state==WAIT (combinational).
//  busy = (state!=IDLE).
// CONFIGURATION
//  DRAW_SCHED_FLUSH_EN defined:
//   Adds input flush (1b). When flush=1: FIFO emptied (pointers and count=0) the same edge.
//   Any push that cycle is discarded; overflow is unaffected.
//   A draw already in GO/WAIT runs to done. If flush arrives in POP, the popped cmd still runs.
//  Not defined: no flush port; FIFO drains only by normal pops.
// TESTING
//  1 Reset: hold resetn=0 3 cycles -> busy=0, count=0, di_go=0, vga_plot=0, overflow=0.
//  2 Single cmd x=100,y=50,drawID=1,card=6'h13: push -> di_go pulses 1 cycle, 3 cycles later.
//    Fields hold 1/6'h13 until di_done; a model drawImage with dx=dy=0 gives vga_x=100, vga_y=50.
//  3 Clip: cmd x=300,y=10 with a 44-wide card -> plot for dx 0..19 only.
//    vga_plot=0 for dx>=20; a 59-row card at y=200 gives no plot for dy>=40.
//  4 Fill: push 9 cmds with a stalled drawImage (DEPTH=8, 1st popped) -> 8 accepted after pop.
//    count=8, cmd_ready=0; 10th push sets overflow=1; all 9 accepted cmds execute in order.
//  5 Simultaneous: full FIFO, push on the POP cycle -> accepted, count unchanged, no overflow.
//  6 DRAW_SCHED_FLUSH_EN: 4 queued, flush during WAIT -> count=0 next edge.
//    The current draw completes and no further di_go fires.

Source files
------------

// File: rtl/draw_scheduler_if.sv
// ----------------------------------------------------------------------------
// draw_scheduler_if
// Command push channel from game/menu logic into the draw scheduler FIFO.
//   cmd_valid  master->slave  push request
//   cmd_data   master->slave  38-bit packed draw command
//                             {x[37:29], y[28:20], drawID[19:16], card[15:10],
//                              menuOFF[9:6], menuID[5:4], menuDepth[3:2], winID[1:0]}
//   cmd_ready  slave->master  FIFO not full (combinational)
// ----------------------------------------------------------------------------
interface draw_scheduler_if;
  logic        cmd_valid;
  logic [37:0] cmd_data;
  logic        cmd_ready;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/draw_scheduler.sv
// ----------------------------------------------------------------------------
// draw_scheduler
// Sequencer in front of drawImage. Draw commands are queued in a FIFO, popped
// one at a time, their image-select fields held stable while drawImage runs,
// and drawImage's pixel offsets are turned into absolute VGA coordinates that
// are clipped to the visible screen.
//
// Ports
//   clock, resetn          clock (posedge) and synchronous active-low reset
//   flush_i                empty the FIFO (only with DRAW_SCHED_FLUSH_EN)
//   cmd_bus                command push channel (draw_scheduler_if.slave)
//   di_go_o / di_done_i    start pulse to / done pulse from drawImage
//   di_*_o fields          held fields of the active command
//   di_ld_pos_i, di_draw_i drawImage position-load and pixel strobes
//   di_dx_i, di_dy_i       drawImage offsets from the command base
//   vga_x_o, vga_y_o       absolute pixel position (9-bit, wraps mod 512)
//   vga_plot_o             VGA write strobe, suppressed off-screen
//   busy_o                 a command is in flight (FSM not idle)
//   count_o                FIFO occupancy
//   overflow_o             sticky: push attempted while full
//
// Configuration macro: DRAW_SCHED_FLUSH_EN adds the flush_i input.
// ----------------------------------------------------------------------------
module draw_scheduler #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int X_MAX = 320,
  parameter int Y_MAX = 240
) (
  input  logic          clock,
  input  logic          resetn,
`ifdef DRAW_SCHED_FLUSH_EN
  input  logic          flush_i,
`endif
  draw_scheduler_if.slave cmd_bus,
  output logic          di_go_o,
  input  logic          di_done_i,
  output logic [3:0]    di_drawID_o,
  output logic [5:0]    di_card_o,
  output logic [3:0]    di_menuOFF_o,
  output logic [1:0]    di_menuID_o,
  output logic [1:0]    di_menuDepth_o,
  output logic [1:0]    di_winID_o,
  input  logic          di_ld_pos_i,
  input  logic          di_draw_i,
  input  logic [8:0]    di_dx_i,
  input  logic [8:0]    di_dy_i,
  output logic [8:0]    vga_x_o,
  output logic [8:0]    vga_y_o,
  output logic          vga_plot_o,
  output logic          busy_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_GO   = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [9:0]  X_LIM   = X_MAX[9:0];
  localparam logic [9:0]  Y_LIM   = Y_MAX[9:0];

  state_t        state_q, state_d;
  logic [37:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [19:0]   field_q, field_d;
  logic [8:0]    base_x_q, base_x_d, base_y_q, base_y_d;
  logic [8:0]    vga_x_q, vga_x_d, vga_y_q, vga_y_d;
  logic          di_go_q;

  logic          flush_s, full_s, pop_s, push_s, ovf_s;
  logic [37:0]   head_s;

`ifdef DRAW_SCHED_FLUSH_EN
  assign flush_s = flush_i;
`else
  assign flush_s = 1'b0;
`endif

  assign full_s = (count_q == DEPTH_C);
  assign pop_s  = (state_q == S_POP);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign push_s = cmd_bus.cmd_valid && (!full_s || pop_s) && !flush_s;
  assign ovf_s  = cmd_bus.cmd_valid && full_s && !pop_s && !flush_s;
  assign head_s = mem_q[rd_ptr_q];

  assign cmd_bus.cmd_ready = !full_s;

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (push_s) mem_q[wr_ptr_q] <= cmd_bus.cmd_data;
  end

  // FSM next state; IDLE does not start a pop on a flush cycle so POP never sees an empty FIFO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if ((count_q != {(AW+1){1'b0}}) && !flush_s) state_d = S_POP;
              else state_d = S_IDLE;
      S_POP:  state_d = S_GO;
      S_GO:   state_d = S_WAIT;
      S_WAIT: if (di_done_i) state_d = S_IDLE;
              else state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO pointer, occupancy and sticky overflow next state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_s) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + 1'b1;
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + 1'b1;
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    if (ovf_s) overflow_d = 1'b1;
    else       overflow_d = overflow_q;
  end

  // Held command fields and pixel coordinates; fields change only while popping.
  always_comb begin
    field_d  = field_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    vga_x_d  = vga_x_q;
    vga_y_d  = vga_y_q;
    if (pop_s) begin
      field_d  = head_s[19:0];
      base_x_d = head_s[37:29];
      base_y_d = head_s[28:20];
    end else begin
      field_d  = field_q;
    end
    // 9-bit sums: carry out is intentionally dropped.
    if (di_ld_pos_i) begin
      vga_x_d = base_x_q + di_dx_i;
      vga_y_d = base_y_q + di_dy_i;
    end else begin
      vga_x_d = vga_x_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      overflow_q <= 1'b0;
      field_q    <= 20'd0;
      base_x_q   <= 9'd0;
      base_y_q   <= 9'd0;
      vga_x_q    <= 9'd0;
      vga_y_q    <= 9'd0;
      di_go_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      field_q    <= field_d;
      base_x_q   <= base_x_d;
      base_y_q   <= base_y_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      di_go_q    <= (state_d == S_GO);
    end
  end

  assign di_go_o        = di_go_q;
  assign di_drawID_o    = field_q[19:16];
  assign di_card_o      = field_q[15:10];
  assign di_menuOFF_o   = field_q[9:6];
  assign di_menuID_o    = field_q[5:4];
  assign di_menuDepth_o = field_q[3:2];
  assign di_winID_o     = field_q[1:0];
  assign vga_x_o        = vga_x_q;
  assign vga_y_o        = vga_y_q;
  assign vga_plot_o     = di_draw_i && ({1'b0, vga_x_q} < X_LIM) &&
                          ({1'b0, vga_y_q} < Y_LIM) && (state_q == S_WAIT);
  assign busy_o         = (state_q != S_IDLE);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;

endmodule
